// File: rtl/regfile_ctrl_pkg.sv
// Shared widths and types for the regfile write-port control slice.
// Build option: WB_BYPASS_EN (see wb_port_arbiter).
package regfile_ctrl_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 1 << REG_AW;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xlen_t;

endpackage

// File: rtl/wb_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, winner index, own rotating pointer.
// The pointer moves to just past the winner, so each winner drops to lowest priority.
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] j;

    // Scan requests starting at the pointer, wrapping modulo N.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr_q) + k) % N);
            if (!any_o && req_i[j]) begin
                any_o = 1'b1;
                idx_o = j;
            end
        end
        if (any_o) begin
            grant_o[idx_o] = 1'b1;
        end
    end

    // Pointer advances past the winner; idle cycles leave it alone.
    always_comb begin
        ptr_d = ptr_q;
        if (any_o) begin
            ptr_d = IW'((int'(idx_o) + 1) % N);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single regfile write port among NUM_REQ writeback sources and
// keeps a pending-write scoreboard. Build option WB_BYPASS_EN adds forwarding.
module wb_port_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter  int NUM_REQ = 3,
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*REG_AW-1:0] req_rd,
    input  logic [NUM_REQ*XLEN-1:0]   req_data,
    output logic                      we,
    output reg_addr_t                 rd_addr,
    output xlen_t                     rd_data,
    input  logic                      alloc_valid,
    input  reg_addr_t                 alloc_rd,
    output logic                      alloc_ready,
    input  reg_addr_t                 rs1_addr,
    input  reg_addr_t                 rs2_addr,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic [NUM_REGS-1:0]       pending,
    output logic                      err_stray,
    output logic                      rs1_fwd_valid,
    output logic                      rs2_fwd_valid,
    output xlen_t                     rs1_fwd_data,
    output xlen_t                     rs2_fwd_data
);

    logic [IW-1:0]       win_idx;
    logic                win_any;
    reg_addr_t           win_rd;
    xlen_t               win_data;
    logic                win_wr;

    logic                we_q,      we_d;
    reg_addr_t           rd_addr_q, rd_addr_d;
    xlen_t               rd_data_q, rd_data_d;
    logic [NUM_REGS-1:0] pend_q,    pend_d;
    logic                err_q,     err_d;
    logic [NUM_REGS-1:0] set_vec,   clr_vec;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (req_valid),
        .grant_o (req_ready),
        .idx_o   (win_idx),
        .any_o   (win_any)
    );

    // Select the winning requester's destination and data.
    always_comb begin
        win_rd   = req_rd[int'(win_idx)*REG_AW +: REG_AW];
        win_data = req_data[int'(win_idx)*XLEN +: XLEN];
        win_wr   = win_any && (win_rd != '0);
    end

    // Write stage: a grant is registered onto the port; x0 never writes.
    always_comb begin
        we_d      = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (win_any) begin
            we_d      = win_wr;
            rd_addr_d = win_rd;
            rd_data_d = win_data;
        end
    end

    // Scoreboard: alloc is judged on pre-clear state; a new reservation
    // wins over a stray clear of the same register.
    always_comb begin
        alloc_ready = (alloc_rd == '0) || !pend_q[alloc_rd];
        set_vec     = '0;
        clr_vec     = '0;
        if (win_wr) begin
            clr_vec[win_rd] = 1'b1;
        end
        if (alloc_valid && alloc_ready && (alloc_rd != '0)) begin
            set_vec[alloc_rd] = 1'b1;
        end
        pend_d = (pend_q & ~clr_vec) | set_vec;
        err_d  = err_q || (win_wr && !pend_q[win_rd]);
    end

    // State registers; reset drops any in-flight write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            pend_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            we_q      <= we_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
        end
    end

    // Outputs and hazard lookups; x0 never reads as busy.
    always_comb begin
        we        = we_q;
        rd_addr   = rd_addr_q;
        rd_data   = rd_data_q;
        pending   = pend_q;
        err_stray = err_q;
        rs1_busy  = (rs1_addr != '0) && pend_q[rs1_addr];
        rs2_busy  = (rs2_addr != '0) && pend_q[rs2_addr];
    end

`ifdef WB_BYPASS_EN
    // Forward the value sitting at the write port before it is readable.
    always_comb begin
        rs1_fwd_valid = we_q && (rd_addr_q == rs1_addr) && (rs1_addr != '0);
        rs2_fwd_valid = we_q && (rd_addr_q == rs2_addr) && (rs2_addr != '0);
        rs1_fwd_data  = rd_data_q;
        rs2_fwd_data  = rd_data_q;
    end
`else
    // No bypass: ports kept for a stable interface, held inactive.
    always_comb begin
        rs1_fwd_valid = 1'b0;
        rs2_fwd_valid = 1'b0;
        rs1_fwd_data  = '0;
        rs2_fwd_data  = '0;
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed cases plus randomized traffic
// compared each cycle against a queue/array level reference model.
module tb_wb_port_arbiter;
    import regfile_ctrl_pkg::*;

    localparam int N  = 3;
    localparam int IW = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [N-1:0]          req_valid;
    logic [N-1:0]          req_ready;
    logic [N*REG_AW-1:0]   req_rd;
    logic [N*XLEN-1:0]     req_data;
    logic                  we;
    reg_addr_t             rd_addr;
    xlen_t                 rd_data;
    logic                  alloc_valid;
    reg_addr_t             alloc_rd;
    logic                  alloc_ready;
    reg_addr_t             rs1_addr;
    reg_addr_t             rs2_addr;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic [NUM_REGS-1:0]   pending;
    logic                  err_stray;
    logic                  rs1_fwd_valid;
    logic                  rs2_fwd_valid;
    xlen_t                 rs1_fwd_data;
    xlen_t                 rs2_fwd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.NUM_REQ(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_rd        (req_rd),
        .req_data      (req_data),
        .we            (we),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .alloc_valid   (alloc_valid),
        .alloc_rd      (alloc_rd),
        .alloc_ready   (alloc_ready),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .pending       (pending),
        .err_stray     (err_stray),
        .rs1_fwd_valid (rs1_fwd_valid),
        .rs2_fwd_valid (rs2_fwd_valid),
        .rs1_fwd_data  (rs1_fwd_data),
        .rs2_fwd_data  (rs2_fwd_data)
    );

    // Simple regfile driven by the DUT port (stores x0 writes raw so
    // an illegal x0 write is observable).
    xlen_t rf_raw [NUM_REGS];
    always @(posedge clk) if (we) rf_raw[rd_addr] <= rd_data;

    function automatic xlen_t rf_read(input reg_addr_t a);
        return (a == '0) ? '0 : rf_raw[a];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int                  m_rr;
    bit                  m_we;
    reg_addr_t           m_addr;
    xlen_t               m_data;
    bit [NUM_REGS-1:0]   m_pend;
    bit                  m_err;
    int                  m_gidx;
    xlen_t               m_rf [NUM_REGS];

    function automatic int pick(input logic [N-1:0] v, input int rr);
        logic [IW-1:0] j;
        for (int k = 0; k < N; k++) begin
            j = IW'((rr + k) % N);
            if (v[j]) return int'(j);
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int        g;
        reg_addr_t r;
        xlen_t     d;
        bit        acc;
        if (!rst_n) begin
            m_rr = 0; m_we = 0; m_addr = '0; m_data = '0;
            m_pend = '0; m_err = 0; m_gidx = -1;
        end else begin
            if (m_we) m_rf[m_addr] = m_data;
            acc = alloc_valid && (alloc_rd == '0 || !m_pend[alloc_rd]);
            g = pick(req_valid, m_rr);
            m_gidx = g;
            if (g >= 0) begin
                r = req_rd[g*REG_AW +: REG_AW];
                d = req_data[g*XLEN +: XLEN];
                if (r != '0 && !m_pend[r]) m_err = 1;
                if (r != '0) m_pend[r] = 0;
                m_we = (r != '0);
                m_addr = r;
                m_data = d;
                m_rr = (g + 1) % N;
            end else begin
                m_we = 0;
            end
            if (acc && alloc_rd != '0) m_pend[alloc_rd] = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) if (rst_n) begin : cmp
        int          g;
        logic [N-1:0] eg;
        bit          e1, e2;
        g  = pick(req_valid, m_rr);
        eg = (g >= 0) ? (N'(1) << g) : '0;
        chk("ready", req_ready, eg);
        chk("we", we, m_we);
        chk("rd_addr", rd_addr, m_addr);
        chk("rd_data", rd_data, m_data);
        chk("pending", pending, m_pend);
        chk("err_stray", err_stray, m_err);
        chk("alloc_ready", alloc_ready,
            alloc_rd == '0 || !m_pend[alloc_rd]);
        chk("rs1_busy", rs1_busy, rs1_addr != '0 && m_pend[rs1_addr]);
        chk("rs2_busy", rs2_busy, rs2_addr != '0 && m_pend[rs2_addr]);
        chk("rf_rs1", rf_read(rs1_addr),
            (rs1_addr == '0) ? '0 : m_rf[rs1_addr]);
`ifdef WB_BYPASS_EN
        e1 = m_we && m_addr == rs1_addr && rs1_addr != '0;
        e2 = m_we && m_addr == rs2_addr && rs2_addr != '0;
        chk("fwd1_v", rs1_fwd_valid, e1);
        chk("fwd2_v", rs2_fwd_valid, e2);
        if (e1) chk("fwd1_d", rs1_fwd_data, m_data);
        if (e2) chk("fwd2_d", rs2_fwd_data, m_data);
`else
        e1 = 0;
        e2 = 0;
        chk("fwd1_v", rs1_fwd_valid, e1);
        chk("fwd2_v", rs2_fwd_valid, e2);
        chk("fwd1_d", rs1_fwd_data, 0);
        chk("fwd2_d", rs2_fwd_data, 0);
`endif
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [N-1:0] gseq [6];
    int           cnt [N];

    initial begin
        for (int i = 0; i < NUM_REGS; i++) begin
            rf_raw[i] = '0;
            m_rf[i]   = '0;
        end
        req_valid = '0; req_rd = '0; req_data = '0;
        alloc_valid = 1'b0; alloc_rd = '0;
        rs1_addr = '0; rs2_addr = '0;
        repeat (3) cyc();

        // reset state
        rst_n = 1'b1;
        alloc_rd = 5'd5;
        #1;
        chk("rst_we", we, 0);
        chk("rst_pending", pending, 0);
        chk("rst_err", err_stray, 0);
        chk("rst_alloc_ready", alloc_ready, 1);

        // single write x1
        alloc_valid = 1'b1; alloc_rd = 5'd1;
        cyc();
        alloc_valid = 1'b0;
        chk("sw_pend_set", pending, 32'h2);
        req_valid = 3'b001;
        req_rd[0 +: REG_AW] = 5'd1;
        req_data[0 +: XLEN] = 32'hDEADBEEF;
        #1;
        chk("sw_ready", req_ready, 3'b001);
        cyc();
        req_valid = '0;
        chk("sw_we", we, 1);
        chk("sw_addr", rd_addr, 1);
        chk("sw_data", rd_data, 32'hDEADBEEF);
        chk("sw_pend_clr", pending, 0);
        cyc();
        chk("sw_rf", rf_read(5'd1), 32'hDEADBEEF);

        // fairness from a fresh pointer
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req_rd = '0;
        for (int i = 0; i < N; i++) req_data[i*XLEN +: XLEN] = XLEN'(i);
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            gseq[k] = req_ready;
            cyc();
        end
        req_valid = '0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int k = 0; k < 6; k++) begin
            chk("fair_seq", gseq[k], N'(1) << (k % 3));
            for (int i = 0; i < N; i++) if (gseq[k][i]) cnt[i]++;
        end
        for (int i = 0; i < N; i++) chk("fair_cnt", cnt[i], 2);

        // x0 writeback
        req_valid = 3'b010;
        req_rd[REG_AW +: REG_AW] = 5'd0;
        req_data[XLEN +: XLEN] = 32'hFFFFFFFF;
        #1;
        chk("x0_ready", req_ready, 3'b010);
        cyc();
        req_valid = '0;
        chk("x0_we", we, 0);
        chk("x0_err", err_stray, 0);
        cyc();
        chk("x0_rf", rf_raw[0], 0);

        // hazard on x7
        alloc_valid = 1'b1; alloc_rd = 5'd7;
        #1;
        chk("hz_alloc1", alloc_ready, 1);
        cyc();
        chk("hz_alloc2", alloc_ready, 0);
        rs1_addr = 5'd7;
        #1;
        chk("hz_busy", rs1_busy, 1);
        alloc_valid = 1'b0;
        cyc();
        chk("hz_busy_hold", rs1_busy, 1);
        req_valid = 3'b100;
        req_rd[2*REG_AW +: REG_AW] = 5'd7;
        req_data[2*XLEN +: XLEN] = 32'h12345678;
        #1;
        chk("hz_ready", req_ready, 3'b100);
        cyc();
        req_valid = '0;
        rs2_addr = 5'd7;
        #1;
        chk("hz_busy_clr", rs1_busy, 0);
        chk("hz_we", we, 1);
        chk("hz_addr", rd_addr, 7);
`ifdef WB_BYPASS_EN
        chk("byp_valid", rs2_fwd_valid, 1);
        chk("byp_data", rs2_fwd_data, 32'h12345678);
`else
        chk("byp_off", rs2_fwd_valid, 0);
`endif

        // stray write to unreserved x9
        req_valid = 3'b001;
        req_rd[0 +: REG_AW] = 5'd9;
        req_data[0 +: XLEN] = 32'h99;
        cyc();
        req_valid = '0;
        chk("stray_err", err_stray, 1);
        chk("stray_we", we, 1);
        chk("stray_addr", rd_addr, 9);

        // reset while a write is at the port
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", we, 0);
        chk("mid_rst_err", err_stray, 0);
        chk("mid_rst_pend", pending, 0);
        cyc();
        rst_n = 1'b1;
        rs1_addr = '0; rs2_addr = '0;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            cyc();
            for (int i = 0; i < N; i++) begin
                if (m_gidx == i) req_valid[i] = 1'b0;
                if (!req_valid[i] && ($urandom % 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_rd[i*REG_AW +: REG_AW] = REG_AW'($urandom % 12);
                    req_data[i*XLEN +: XLEN] = $urandom;
                end
            end
            alloc_valid = 1'($urandom % 2);
            alloc_rd = REG_AW'($urandom % 12);
            rs1_addr = REG_AW'($urandom % 12);
            rs2_addr = REG_AW'($urandom % 12);
        end
        req_valid = '0;
        alloc_valid = 1'b0;
        repeat (2) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
